// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // 2'd3 is unreachable; the FSM decodes it back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Combinational 1-bit full adder, the single arithmetic cell of the serial adder datapath.
module full_adder_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: {o_cout,o_sum} = i_a + i_b + i_cin, one bit per clock, LSB first.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CNT_W-1:0] r_cnt;
   logic             w_accept;
   logic             w_shift;
   logic             w_last;
   logic             w_bit_sum;
   logic             w_bit_carry;

   full_adder_bit u_fa (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .o_sum  (w_bit_sum),
      .o_cout (w_bit_carry)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_shift      = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_accept     = 1'b1;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            o_busy  = 1'b1;
            w_shift = 1'b1;
            if (w_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            o_busy       = 1'b1;
            o_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Sum bits enter at the MSB so that after WIDTH steps bit 0 lands in position 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= i_a;
         r_b     <= i_b;
         r_sum   <= '0;
         r_carry <= i_cin;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else if (w_shift) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_bit_carry;
         r_sum   <= {w_bit_sum, r_sum[WIDTH-1:1]};
         if (w_last) begin
            r_cout <= w_bit_carry;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (WIDTH=8) with hand-computed expectations.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[7];

   serial_adder #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_a     (a),
      .i_b     (b),
      .i_cin   (cin),
      .o_busy  (busy),
      .o_done  (done),
      .o_sum   (sum),
      .o_cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One operation from a single-cycle start; optionally disturbs start/a/b/cin while shifting.
   task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic [W-1:0] esum, input logic ecout,
                         input bit disturb);
      int done_cyc;
      int n_done;
      int n_busy;
      done_cyc = 0;
      n_done   = 0;
      n_busy   = 0;
      @(negedge clk);
      a     = va;
      b     = vb;
      cin   = vcin;
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            if (disturb) begin
               a   = 8'hC3;
               b   = 8'h3C;
               cin = 1'b1;
            end
         end
         if (disturb && c == 3) begin
            start = 1'b1;
            a     = 8'hAA;
            b     = 8'h55;
         end
         if (disturb && c == 5) start = 1'b0;
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            done_cyc = c;
            chk({name, " sum"}, 32'(sum), 32'(esum));
            chk({name, " cout"}, 32'(cout), 32'(ecout));
         end
      end
      chk({name, " done_cycle"}, 32'(done_cyc), 32'd9);
      chk({name, " done_count"}, 32'(n_done), 32'd1);
      chk({name, " busy_cycles"}, 32'(n_busy), 32'd9);
      $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d done@%0d", name, va, vb, vcin,
               sum, cout, done_cyc);
   endtask

   initial begin
      int   n_done;
      int   gap;
      bit   got;
      logic av, bv, bin, borrow;
      logic [W-1:0] diff;

      n_checks = 0;
      n_fail   = 0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      rst_n    = 1'b0;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset sum", 32'(sum), 32'd0);
      chk("reset cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].exp_sum, vecs[i].exp_cout, 1'b0);
      end

      run_op("ignore_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);

      // Reset while bit 4 is being shifted; outputs clear at once and no done follows.
      @(negedge clk);
      a     = 8'h55;
      b     = 8'h33;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset done", 32'(done), 32'd0);
      chk("midreset sum", 32'(sum), 32'd0);
      chk("midreset cout", 32'(cout), 32'd0);
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("midreset no_done", 32'(n_done), 32'd0);
      $display("op midreset: done pulses after abort=%0d", n_done);
      run_op("after_reset", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);

      // Inverse of the subtractor with start held high: IDLE is re-entered one edge after
      // done and the held start is accepted on the following edge, so done repeats every 10.
      @(negedge clk);
      gap = 0;
      for (int p = 0; p < 8; p++) begin
         av     = p[2];
         bv     = p[1];
         bin    = p[0];
         diff   = 8'({7'b0, av}) - 8'({7'b0, bv}) - 8'({7'b0, bin});
         borrow = (32'(av) < 32'(bv) + 32'(bin));
         a      = diff;
         b      = 8'({7'b0, bv});
         cin    = bin;
         start  = 1'b1;
         got    = 1'b0;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            gap++;
            if (done) got = 1'b1;
         end
         chk($sformatf("inv%0d done_seen", p), 32'(got), 32'd1);
         chk($sformatf("inv%0d sum", p), 32'(sum), 32'(av));
         chk($sformatf("inv%0d cout", p), 32'(cout), 32'(borrow));
         if (p > 0) chk($sformatf("inv%0d period", p), 32'(gap), 32'd10);
         $display("op inv%0d: diff=%02h b=%0d bin=%0d -> sum=%02h cout=%0d gap=%0d", p, diff,
                  bv, bin, sum, cout, gap);
         gap = 0;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("final idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
